// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_pkg
// Brief    : Shared CPU definitions for hazard detection: register index
//            width, scoreboard slot layout and forward-select encodings.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int FWD_SEL_RF = 0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     reg_write;
        logic     is_load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_slot_cmp.sv
`default_nettype none
// ============================================================================
// Module   : hazard_slot_cmp
// Brief    : Compares one scoreboard slot against one ID source operand and
//            reports whether it is the producer and whether its data is ready.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_slot_cmp
    import hazard_unit_pkg::*;
#(
    parameter int SLOT_IDX = 1,
    parameter int LOAD_LAT = 1
) (
    input  logic                 i_slot_valid,
    input  logic [REG_IDX_W-1:0] i_slot_rd,
    input  logic                 i_slot_reg_write,
    input  logic                 i_slot_is_load,
    input  logic                 i_src_use,
    input  logic [REG_IDX_W-1:0] i_src_idx,
    output logic                 o_match,
    output logic                 o_ready
);

    // Load data exists only once the load has travelled past its latency.
    localparam logic C_PAST_LOAD_LAT = (SLOT_IDX > LOAD_LAT);

    assign o_match = i_src_use && (i_src_idx != '0) && i_slot_valid &&
                     i_slot_reg_write && (i_slot_rd == i_src_idx);
    assign o_ready = !i_slot_is_load || C_PAST_LOAD_LAT;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Brief    : Scoreboard-based stall / forwarding control for an in-order
//            pipeline with DEPTH in-flight slots behind ID.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         id_valid,
    input  logic [REG_IDX_W-1:0]         id_rs1,
    input  logic [REG_IDX_W-1:0]         id_rs2,
    input  logic                         id_use_rs1,
    input  logic                         id_use_rs2,
    input  logic [REG_IDX_W-1:0]         id_rd,
    input  logic                         id_reg_write,
    input  logic                         id_is_load,
    input  logic                         flush,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rs1,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rs2,
    output logic [31:0]                  stall_cycles
);

    localparam int   FWD_W    = $clog2(DEPTH+1);
    localparam logic C_FWD_ON = (FWD_EN != 0);

    // Index 0 is slot 1 (EX), index DEPTH-1 is slot DEPTH (WB).
    slot_t       slot_q [DEPTH];
    slot_t       slot_d [DEPTH];
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    logic [DEPTH-1:0] w_match_rs1;
    logic [DEPTH-1:0] w_ready_rs1;
    logic [DEPTH-1:0] w_match_rs2;
    logic [DEPTH-1:0] w_ready_rs2;

    logic             w_hit_rs1;
    logic             w_hit_rs2;
    logic             w_rdy_rs1;
    logic             w_rdy_rs2;
    logic [FWD_W-1:0] w_slot_rs1;
    logic [FWD_W-1:0] w_slot_rs2;
    logic             w_haz_rs1;
    logic             w_haz_rs2;
    logic             w_stall;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_slot
            hazard_slot_cmp #(
                .SLOT_IDX (k + 1),
                .LOAD_LAT (LOAD_LAT)
            ) u_cmp_rs1 (
                .i_slot_valid     (slot_q[k].valid),
                .i_slot_rd        (slot_q[k].rd),
                .i_slot_reg_write (slot_q[k].reg_write),
                .i_slot_is_load   (slot_q[k].is_load),
                .i_src_use        (id_use_rs1),
                .i_src_idx        (id_rs1),
                .o_match          (w_match_rs1[k]),
                .o_ready          (w_ready_rs1[k])
            );

            hazard_slot_cmp #(
                .SLOT_IDX (k + 1),
                .LOAD_LAT (LOAD_LAT)
            ) u_cmp_rs2 (
                .i_slot_valid     (slot_q[k].valid),
                .i_slot_rd        (slot_q[k].rd),
                .i_slot_reg_write (slot_q[k].reg_write),
                .i_slot_is_load   (slot_q[k].is_load),
                .i_src_use        (id_use_rs2),
                .i_src_idx        (id_rs2),
                .o_match          (w_match_rs2[k]),
                .o_ready          (w_ready_rs2[k])
            );
        end
    endgenerate

    // Priority encode: scan oldest to youngest so the youngest match wins.
    always_comb begin
        w_hit_rs1  = 1'b0;
        w_rdy_rs1  = 1'b1;
        w_slot_rs1 = FWD_W'(FWD_SEL_RF);
        w_hit_rs2  = 1'b0;
        w_rdy_rs2  = 1'b1;
        w_slot_rs2 = FWD_W'(FWD_SEL_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match_rs1[k]) begin
                w_hit_rs1  = 1'b1;
                w_rdy_rs1  = w_ready_rs1[k];
                w_slot_rs1 = FWD_W'(k + 1);
            end
            if (w_match_rs2[k]) begin
                w_hit_rs2  = 1'b1;
                w_rdy_rs2  = w_ready_rs2[k];
                w_slot_rs2 = FWD_W'(k + 1);
            end
        end
    end

    // Without forwarding only the WB slot (register-file write-through) is safe.
    always_comb begin
        if (C_FWD_ON) begin
            w_haz_rs1 = w_hit_rs1 && !w_rdy_rs1;
            w_haz_rs2 = w_hit_rs2 && !w_rdy_rs2;
        end else begin
            w_haz_rs1 = w_hit_rs1 && (w_slot_rs1 < FWD_W'(DEPTH));
            w_haz_rs2 = w_hit_rs2 && (w_slot_rs2 < FWD_W'(DEPTH));
        end
        w_stall = !reset && id_valid && !flush && (w_haz_rs1 || w_haz_rs2);
    end

    always_comb begin
        slot_d[0] = SLOT_BUBBLE;
        if (id_valid && !w_stall && !flush) begin
            slot_d[0].valid     = 1'b1;
            slot_d[0].rd        = id_rd;
            slot_d[0].reg_write = id_reg_write;
            slot_d[0].is_load   = id_is_load;
        end
        for (int k = 1; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k-1];
        end

        stall_cycles_d = stall_cycles_q;
        if (w_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= SLOT_BUBBLE;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall        = w_stall;
    assign fwd_sel_rs1  = (C_FWD_ON && w_hit_rs1 && !w_stall) ? w_slot_rs1 : FWD_W'(FWD_SEL_RF);
    assign fwd_sel_rs2  = (C_FWD_ON && w_hit_rs2 && !w_stall) ? w_slot_rs2 : FWD_W'(FWD_SEL_RF);
    assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit
// Brief    : Self-checking bench for hazard_unit: directed scenarios plus a
//            randomized run against an age-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int FW       = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [4:0]    id_rd;
    logic          id_reg_write;
    logic          id_is_load;
    logic          flush;

    logic          stall_f, stall_n;
    logic [FW-1:0] s1_f, s2_f, s1_n, s2_n;
    logic [31:0]   cyc_f, cyc_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per configuration, what entered EX 1..DEPTH cycles ago (age 0 = EX).
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } ent_t;
    ent_t        hist [2][DEPTH];
    int unsigned cnt  [2];

    always #5 clk = ~clk;

    hazard_unit #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(1)) dut_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .stall(stall_f), .fwd_sel_rs1(s1_f), .fwd_sel_rs2(s2_f), .stall_cycles(cyc_f)
    );

    hazard_unit #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(0)) dut_nofwd (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
        .stall(stall_n), .fwd_sel_rs1(s1_n), .fwd_sel_rs2(s2_n), .stall_cycles(cyc_n)
    );

    function automatic int find_producer(int m, bit use_src, int rs);
        if (!use_src || rs == 0) return 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (hist[m][a].v && hist[m][a].rw && hist[m][a].rd == rs) return a + 1;
        end
        return 0;
    endfunction

    function automatic bit src_blocks(int m, int slot);
        if (slot == 0) return 1'b0;
        if (m == 0) return hist[m][slot-1].ld && (slot <= LOAD_LAT);
        return slot < DEPTH;
    endfunction

    function automatic bit exp_stall(int m);
        int p1, p2;
        p1 = find_producer(m, id_use_rs1, int'(id_rs1));
        p2 = find_producer(m, id_use_rs2, int'(id_rs2));
        if (!id_valid || flush) return 1'b0;
        return src_blocks(m, p1) || src_blocks(m, p2);
    endfunction

    function automatic void advance_model();
        for (int m = 0; m < 2; m++) begin
            bit st;
            st = exp_stall(m);
            for (int a = DEPTH - 1; a > 0; a--) hist[m][a] = hist[m][a-1];
            if (id_valid && !st && !flush)
                hist[m][0] = '{1'b1, int'(id_rd), id_reg_write, id_is_load};
            else
                hist[m][0] = '{1'b0, 0, 1'b0, 1'b0};
            if (st && cnt[m] != 32'hFFFF_FFFF) cnt[m]++;
        end
    endfunction

    task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit rw, bit ld);
        id_valid     = v;
        id_rs1       = 5'(rs1);
        id_use_rs1   = u1;
        id_rs2       = 5'(rs2);
        id_use_rs2   = u2;
        id_rd        = 5'(rd);
        id_reg_write = rw;
        id_is_load   = ld;
        flush        = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            cnt[m] = 0;
            for (int a = 0; a < DEPTH; a++) hist[m][a] = '{1'b0, 0, 1'b0, 1'b0};
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 5, 1, 1);
        next_cycle();
        drive(1, 5, 1, 5, 1, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (stall_f !== 1'b0)  begin n_fail++; $display("FAIL reset stall_f: got %b want 0", stall_f); end
        n_checks++; if (s1_f !== '0)       begin n_fail++; $display("FAIL reset fwd_sel_rs1: got %0d want 0", s1_f); end
        n_checks++; if (s2_f !== '0)       begin n_fail++; $display("FAIL reset fwd_sel_rs2: got %0d want 0", s2_f); end
        n_checks++; if (cyc_f !== 32'd0)   begin n_fail++; $display("FAIL reset stall_cycles: got %0d want 0", cyc_f); end
        n_checks++; if (stall_n !== 1'b0)  begin n_fail++; $display("FAIL reset stall_n: got %b want 0", stall_n); end
        next_cycle();
        do_reset();
        drive(1, 5, 1, 5, 1, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (s1_f !== '0 || stall_f !== 1'b0) begin n_fail++; $display("FAIL reset_empty: sel1=%0d stall=%b want 0/0", s1_f, stall_f); end
        next_cycle();
    endtask

    task automatic test_alu_b2b();
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 0);
        next_cycle();
        drive(1, 5, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (stall_f !== 1'b0) begin n_fail++; $display("FAIL alu_b2b stall: got %b want 0", stall_f); end
        n_checks++; if (s1_f !== 2'd1)    begin n_fail++; $display("FAIL alu_b2b fwd_sel_rs1: got %0d want 1", s1_f); end
        n_checks++; if (s2_f !== 2'd0)    begin n_fail++; $display("FAIL alu_b2b fwd_sel_rs2: got %0d want 0", s2_f); end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 6, 1, 1);
        next_cycle();
        drive(1, 0, 0, 6, 1, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (stall_f !== 1'b1) begin n_fail++; $display("FAIL load_use stall c1: got %b want 1", stall_f); end
        n_checks++; if (s2_f !== 2'd0)    begin n_fail++; $display("FAIL load_use sel c1: got %0d want 0", s2_f); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (stall_f !== 1'b0) begin n_fail++; $display("FAIL load_use stall c2: got %b want 0", stall_f); end
        n_checks++; if (s2_f !== 2'd2)    begin n_fail++; $display("FAIL load_use sel c2: got %0d want 2", s2_f); end
        n_checks++; if (cyc_f !== 32'd1)  begin n_fail++; $display("FAIL load_use stall_cycles: got %0d want 1", cyc_f); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (cyc_f !== 32'd1)  begin n_fail++; $display("FAIL load_use stall_cycles hold: got %0d want 1", cyc_f); end
        next_cycle();
    endtask

    task automatic test_x0_unused();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        next_cycle();
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (stall_f !== 1'b0 || stall_n !== 1'b0) begin n_fail++; $display("FAIL x0 stall: got %b/%b want 0/0", stall_f, stall_n); end
        n_checks++; if (s1_f !== 2'd0 || s2_f !== 2'd0)       begin n_fail++; $display("FAIL x0 sel: got %0d/%0d want 0/0", s1_f, s2_f); end
        next_cycle();
        drive(1, 0, 0, 0, 0, 8, 1, 1);
        next_cycle();
        drive(1, 8, 0, 8, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (stall_f !== 1'b0 || stall_n !== 1'b0) begin n_fail++; $display("FAIL unused stall: got %b/%b want 0/0", stall_f, stall_n); end
        n_checks++; if (s1_f !== 2'd0 || s2_f !== 2'd0)       begin n_fail++; $display("FAIL unused sel: got %0d/%0d want 0/0", s1_f, s2_f); end
        next_cycle();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 0, 0, 6, 1, 1);
        next_cycle();
        drive(1, 0, 0, 6, 1, 9, 1, 0);
        @(negedge clk);
        n_checks++; if (stall_f !== 1'b1) begin n_fail++; $display("FAIL flush pre stall: got %b want 1", stall_f); end
        flush = 1'b1;
        #1;
        n_checks++; if (stall_f !== 1'b0) begin n_fail++; $display("FAIL flush stall_f: got %b want 0", stall_f); end
        n_checks++; if (stall_n !== 1'b0) begin n_fail++; $display("FAIL flush stall_n: got %b want 0", stall_n); end
        next_cycle();
        drive(1, 9, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (s1_f !== 2'd0)    begin n_fail++; $display("FAIL flush bubble sel: got %0d want 0", s1_f); end
        n_checks++; if (stall_n !== 1'b0) begin n_fail++; $display("FAIL flush bubble stall_n: got %b want 0", stall_n); end
        n_checks++; if (cyc_f !== 32'd0)  begin n_fail++; $display("FAIL flush stall_cycles: got %0d want 0", cyc_f); end
        next_cycle();
    endtask

    task automatic test_nofwd();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        next_cycle();
        drive(1, 7, 1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (stall_n !== (c < 2)) begin n_fail++; $display("FAIL nofwd stall c%0d: got %b want %b", c, stall_n, c < 2); end
            n_checks++; if (s1_n !== 2'd0)       begin n_fail++; $display("FAIL nofwd sel c%0d: got %0d want 0", c, s1_n); end
            next_cycle();
        end
        @(negedge clk);
        n_checks++; if (cyc_n !== 32'd2) begin n_fail++; $display("FAIL nofwd stall_cycles: got %0d want 2", cyc_n); end
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 0, 0, 0, 0, 7, 1, 0);
        next_cycle();
        drive(1, 7, 1, 0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        n_checks++; if (stall_n !== 1'b1 || cyc_n !== 32'd1) begin n_fail++; $display("FAIL areset pre: stall=%b cycles=%0d want 1/1", stall_n, cyc_n); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (stall_n !== 1'b0) begin n_fail++; $display("FAIL areset stall: got %b want 0", stall_n); end
        n_checks++; if (cyc_n !== 32'd0)  begin n_fail++; $display("FAIL areset stall_cycles: got %0d want 0", cyc_n); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_n !== 1'b0 || stall_f !== 1'b0) begin n_fail++; $display("FAIL areset post stall: got %b/%b want 0/0", stall_n, stall_f); end
        n_checks++; if (s1_f !== 2'd0)                        begin n_fail++; $display("FAIL areset post sel: got %0d want 0", s1_f); end
        next_cycle();
    endtask

    task automatic test_drain();
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 1);
        next_cycle();
        drive(1, 0, 0, 0, 0, 4, 1, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < DEPTH; c++) next_cycle();
        drive(1, 3, 1, 4, 1, 0, 0, 0);
        @(negedge clk);
        n_checks++; if (stall_f !== 1'b0 || stall_n !== 1'b0) begin n_fail++; $display("FAIL drain stall: got %b/%b want 0/0", stall_f, stall_n); end
        n_checks++; if (s1_f !== 2'd0 || s2_f !== 2'd0)       begin n_fail++; $display("FAIL drain sel: got %0d/%0d want 0/0", s1_f, s2_f); end
        next_cycle();
    endtask

    task automatic test_random();
        bit            est;
        int            p1, p2, e1, e2;
        logic          a_st;
        logic [FW-1:0] a1, a2;
        logic [31:0]   a_cnt;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(7) != 0, $urandom_range(7), $urandom_range(1), $urandom_range(7),
                  $urandom_range(1), $urandom_range(7), $urandom_range(1), $urandom_range(2) == 0);
            flush = ($urandom_range(9) == 0);
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                p1    = find_producer(m, id_use_rs1, int'(id_rs1));
                p2    = find_producer(m, id_use_rs2, int'(id_rs2));
                est   = exp_stall(m);
                e1    = (m == 1 || est) ? 0 : p1;
                e2    = (m == 1 || est) ? 0 : p2;
                a_st  = (m == 0) ? stall_f : stall_n;
                a1    = (m == 0) ? s1_f : s1_n;
                a2    = (m == 0) ? s2_f : s2_n;
                a_cnt = (m == 0) ? cyc_f : cyc_n;
                n_checks++; if (a_st !== est)        begin n_fail++; $display("FAIL rand[%0d] m%0d stall: got %b want %b", i, m, a_st, est); end
                n_checks++; if (a1 !== FW'(e1))      begin n_fail++; $display("FAIL rand[%0d] m%0d sel1: got %0d want %0d", i, m, a1, e1); end
                n_checks++; if (a2 !== FW'(e2))      begin n_fail++; $display("FAIL rand[%0d] m%0d sel2: got %0d want %0d", i, m, a2, e2); end
                n_checks++; if (a_cnt !== cnt[m])    begin n_fail++; $display("FAIL rand[%0d] m%0d stall_cycles: got %0d want %0d", i, m, a_cnt, cnt[m]); end
            end
            advance_model();
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_b2b();
        test_load_use();
        test_x0_unused();
        test_flush();
        test_nofwd();
        test_async_reset();
        test_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3, giving the number of in-flight slots behind ID; slot 1 is EX and slot DEPTH is WB.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, giving the slots after EX before load data is forwardable; legal range 1..DEPTH-1.
REQ-003 The block SHALL have parameter FWD_EN, default 1; value 0 disables forwarding, so every pending producer stalls.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port id_valid, input, 1 bit: the ID stage holds a real instruction.
REQ-007 The block SHALL have ports id_rs1 and id_rs2, input, 5 bits each: ID source register indices.
REQ-008 The block SHALL have ports id_use_rs1 and id_use_rs2, input, 1 bit each: the ID instruction reads that source.
REQ-009 The block SHALL have port id_rd, input, 5 bits: ID destination register index.
REQ-010 The block SHALL have port id_reg_write, input, 1 bit: the ID instruction writes id_rd.
REQ-011 The block SHALL have port id_is_load, input, 1 bit: the ID instruction is a load.
REQ-012 The block SHALL have port flush, input, 1 bit: EX redirects the PC, so the ID/IF contents are wrong-path.
REQ-013 The block SHALL have port stall, output, 1 bit: hold PC and the IF/ID register, and insert a bubble into ID/EX.
REQ-014 The block SHALL have ports fwd_sel_rs1 and fwd_sel_rs2, output, $clog2(DEPTH+1) bits each: 0 selects the register file, k selects the result of slot k.
REQ-015 The block SHALL have port stall_cycles, output, 32 bits: saturating count of cycles with stall=1.

Function
REQ-016 The block SHALL keep a scoreboard of DEPTH slots, each holding {valid, rd, reg_write, is_load}.
REQ-017 On every clock edge, slot k+1 SHALL take the contents of slot k, and slot DEPTH SHALL retire.
REQ-018 Slot 1 SHALL load the ID entry when id_valid=1, stall=0 and flush=0; otherwise slot 1 SHALL load a bubble (valid=0).
REQ-019 For each source with use=1 and rs!=0, the matching slot SHALL be the smallest k with valid=1, reg_write=1 and rd==rs.
REQ-020 A source with use=0, or with rs=0, SHALL never match: forward select 0, no stall contribution.
REQ-021 The producer in slot k SHALL be ready when is_load=0, or when k>LOAD_LAT.
REQ-022 With FWD_EN=1, stall SHALL be 1 when any used source's matching slot holds a producer that is not ready.
REQ-023 With FWD_EN=0, stall SHALL be 1 when any used source has a match in a slot k<DEPTH.
REQ-024 When no match exists, or stall=1, or FWD_EN=0, fwd_sel SHALL be 0; otherwise fwd_sel SHALL be the matching k.
REQ-025 Slot DEPTH SHALL be treated as register-file write-through: a match there with FWD_EN=0 gives fwd_sel=0 and no stall.
REQ-026 stall and fwd_sel SHALL be combinational from the scoreboard and ID inputs; there is no added latency.
REQ-027 stall SHALL be forced to 0 when flush=1 or id_valid=0, and flush SHALL take priority over stall.
REQ-028 stall_cycles SHALL increment by 1 on each edge with stall=1 and SHALL hold at 0xFFFFFFFF.
REQ-029 A DEPTH-cycle stall-free sequence SHALL drain the scoreboard, with no residual stall afterwards.

Reset
REQ-030 While reset=1, every slot valid SHALL be 0 and stall_cycles SHALL be 0, asynchronously.
REQ-031 While reset=1, the outputs SHALL be stall=0, fwd_sel_rs1=0 and fwd_sel_rs2=0.
REQ-032 A reset asserted mid-stall SHALL discard all in-flight entries, and the first post-reset cycle SHALL show no hazard.

Structure
REQ-033 The register-index width (5) and the fwd_sel encoding constants (0 = register file) SHALL live in the shared CPU package.
REQ-034 The block SHALL use one sub-module, hazard_slot_cmp, which compares one slot with one source and returns {match, ready}.
REQ-035 The block SHALL instantiate hazard_slot_cmp DEPTH×2 times via generate, and SHALL select the youngest match with a priority encoder.

Verification
REQ-036 The bench SHALL cover ALU back-to-back: add x5, then id_rs1=5 next cycle -> stall=0 and fwd_sel_rs1=1.
REQ-037 The bench SHALL cover load-use: load x6, then id_rs2=6 -> stall=1 for exactly 1 cycle, then fwd_sel_rs2=2, and stall_cycles=1.
REQ-038 The bench SHALL cover the x0 and unused-source cases: a producer with rd=0 or a source with use=0 -> stall=0 and fwd_sel=0.
REQ-039 The bench SHALL cover flush during a load-use stall: flush=1 -> stall=0 the same cycle, and slot 1 becomes a bubble the next cycle.
REQ-040 The bench SHALL cover FWD_EN=0 with DEPTH=3: add x7, then use x7 -> stall for 2 cycles, then fwd_sel=0.
REQ-041 The bench SHALL cover reset asserted asynchronously mid-stall: stall=0 and stall_cycles=0 immediately, and the scoreboard is empty after release.
